data_cache: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache: the responder for the CPU

---
 rtl/data_cache.sv | 131 +++++++++++++
 tb/tb_data_cache.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU memory
// stage (busywait handshake) and a 128-bit block main-memory interface.
module data_cache #(
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         read,
  input  logic         write,
  input  logic [31:0]  address,
  input  logic [31:0]  writedata,
  output logic [31:0]  readdata,
  output logic         busywait,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_address,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  localparam int unsigned LINES    = 2 ** INDEX_BITS;
  localparam int unsigned TAG_BITS = 28 - INDEX_BITS;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] REFILL    = 2'd2;

  logic [1:0]          state;
  logic [1:0]          next_state;
  logic [LINES-1:0]    valid;
  logic [LINES-1:0]    dirty;
  logic [TAG_BITS-1:0] tags  [LINES];
  logic [127:0]        lines [LINES];
  logic [27:0]         miss_block;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag_in;
  logic [6:0]            word_lsb;
  logic [INDEX_BITS-1:0] miss_idx;
  logic [TAG_BITS-1:0]   miss_tag;
  logic                  request;
  logic                  hit;
  logic                  idle_hit;
  logic                  unused_bits;

  assign idx         = address[3+INDEX_BITS:4];
  assign tag_in      = address[31:4+INDEX_BITS];
  assign word_lsb    = {address[3:2], 5'd0};
  assign miss_idx    = miss_block[INDEX_BITS-1:0];
  assign miss_tag    = miss_block[27:INDEX_BITS];
  assign request     = read | write;
  assign hit         = valid[idx] && (tags[idx] == tag_in);
  assign idle_hit    = (state == IDLE) && hit;
  assign unused_bits = ^address[1:0];

  assign busywait = request && !idle_hit;
  assign readdata = (read && !write && idle_hit) ? lines[idx][word_lsb +: 32] : 32'd0;

  // Memory-side outputs depend only on the state and the latched miss block.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = 28'd0;
    mem_writedata = 128'd0;
    case (state)
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {tags[miss_idx], miss_idx};
        mem_writedata = lines[miss_idx];
      end
      REFILL: begin
        mem_read    = 1'b1;
        mem_address = miss_block;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A dropped request still lets the transfer in flight finish before idling.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (request && !hit) next_state = dirty[idx] ? WRITEBACK : REFILL;
      WRITEBACK: if (!mem_busywait)   next_state = request ? REFILL : IDLE;
      REFILL:    if (!mem_busywait)   next_state = IDLE;
      default:                        next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= '0;
      dirty      <= '0;
      miss_block <= 28'd0;
    end else begin
      case (state)
        IDLE: begin
          if (write && hit)          dirty[idx] <= 1'b1;
          else if (request && !hit)  miss_block <= address[31:4];
        end
        WRITEBACK: if (!mem_busywait) dirty[miss_idx] <= 1'b0;
        REFILL: begin
          if (!mem_busywait) begin
            valid[miss_idx] <= 1'b1;
            dirty[miss_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage needs no reset; valid bits gate its use.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == IDLE && write && hit) begin
        lines[idx][word_lsb +: 32] <= writedata;
      end else if (state == REFILL && !mem_busywait) begin
        lines[miss_idx] <= mem_readdata;
        tags[miss_idx]  <= miss_tag;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus random traffic
// against a line-level cache model and a block-level memory model.
module tb_data_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic         read;
  logic         write;
  logic [31:0]  address;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int checks = 0;
  int errors = 0;

  bit           m_valid [8];
  bit           m_dirty [8];
  logic [24:0]  m_tag   [8];
  logic [127:0] m_data  [8];
  logic [127:0] mem_m   [logic [27:0]];

  data_cache dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .busywait(busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] mem_get(input logic [27:0] b);
    logic [31:0] s;
    if (mem_m.exists(b)) return mem_m[b];
    s = {4'h0, b} * 32'h9E37_79B9;
    return {s ^ 32'h3333_3333, s ^ 32'h2222_2222, s ^ 32'h1111_1111, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // One CPU access; the model decides hit/miss, write-back and expected data.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input bit drop);
    logic [2:0]   i;
    logic [24:0]  t;
    int           w;
    bit           miss;
    logic [127:0] blk;
    i = a[6:4];
    t = a[31:7];
    w = int'(a[3:2]);
    miss = !(m_valid[i] && m_tag[i] == t);
    step();
    read = rd; write = wr; address = a; writedata = d; mem_busywait = 1'b1;
    #1;
    checks++;
    if (busywait !== miss) begin
      errors++; $display("FAIL req_busywait a=%h: got %b want %b", a, busywait, miss);
    end
    if (miss) begin
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
        errors++; $display("FAIL idle_mem a=%h: got rd=%b wr=%b want 0 0", a, mem_read, mem_write);
      end
      if (m_dirty[i]) begin
        for (int k = 0; k <= lat; k++) begin
          step();
          mem_busywait = (k < lat);
          #1;
          checks++;
          if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== {m_tag[i], i}
              || mem_writedata !== m_data[i]) begin
            errors++;
            $display("FAIL writeback a=%h: got wr=%b rd=%b addr=%h data=%h want 1 0 %h %h",
                     a, mem_write, mem_read, mem_address, mem_writedata, {m_tag[i], i}, m_data[i]);
          end
        end
        mem_m[{m_tag[i], i}] = m_data[i];
        m_dirty[i] = 1'b0;
      end
      blk = mem_get({t, i});
      for (int k = 0; k <= lat; k++) begin
        step();
        if (drop) begin read = 1'b0; write = 1'b0; end
        mem_busywait = (k < lat);
        mem_readdata = blk;
        #1;
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== {t, i}
            || busywait !== !drop) begin
          errors++;
          $display("FAIL refill a=%h: got rd=%b wr=%b addr=%h bw=%b want 1 0 %h %b",
                   a, mem_read, mem_write, mem_address, busywait, {t, i}, !drop);
        end
      end
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
      m_data[i]  = blk;
      m_dirty[i] = 1'b0;
      step();
      mem_busywait = 1'b1;
      mem_readdata = '0;
      #1;
      checks++;
      if (busywait !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
        errors++;
        $display("FAIL post_refill a=%h: got bw=%b rd=%b wr=%b want 0 0 0",
                 a, busywait, mem_read, mem_write);
      end
      if (drop) return;
    end
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== 28'd0) begin
      errors++;
      $display("FAIL hit_mem a=%h: got rd=%b wr=%b addr=%h want 0 0 0", a, mem_read, mem_write, mem_address);
    end
    if (rd && !wr) begin
      checks++;
      if (readdata !== m_data[i][w*32 +: 32]) begin
        errors++; $display("FAIL readdata a=%h: got %h want %h", a, readdata, m_data[i][w*32 +: 32]);
      end
    end else if (!rd) begin
      checks++;
      if (readdata !== 32'd0) begin
        errors++; $display("FAIL write_readdata a=%h: got %h want 0", a, readdata);
      end
    end
    if (wr) begin
      m_data[i][w*32 +: 32] = d;
      m_dirty[i] = 1'b1;
    end
    step();
    read = 1'b0; write = 1'b0;
    #1;
    checks++;
    if (busywait !== 1'b0 || readdata !== 32'd0) begin
      errors++; $display("FAIL idle_out a=%h: got bw=%b rd=%h want 0 0", a, busywait, readdata);
    end
  endtask

  task automatic test_reset();
    step();
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    mem_busywait = 1'b1; mem_readdata = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    model_clear();
    checks++;
    if (readdata !== 32'd0 || busywait !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0
        || mem_address !== 28'd0 || mem_writedata !== 128'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%h bw=%b mr=%b mw=%b ma=%h want all zero",
               readdata, busywait, mem_read, mem_write, mem_address);
    end
  endtask

  task automatic test_directed();
    mem_m[28'h000_0001] = {4{32'hA5A5_A5A5}};
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3, 1'b0);
    access(1'b0, 1'b1, 32'h0000_0014, 32'h1234_5678, 0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0014, 32'h0, 0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0090, 32'h0, 1, 1'b0);
    checks++;
    if (mem_m[28'h000_0001][63:32] !== 32'h1234_5678) begin
      errors++; $display("FAIL wb_word1: got %h want 12345678", mem_m[28'h000_0001][63:32]);
    end
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0014, 32'h0, 0, 1'b0);
  endtask

  task automatic test_read_write_both();
    access(1'b1, 1'b1, 32'h0000_0018, 32'hCAFE_F00D, 0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0018, 32'h0, 0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0090, 32'h0, 0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0018, 32'h0, 1, 1'b0);
  endtask

  task automatic test_reset_mid_refill();
    step();
    read = 1'b1; address = 32'h0000_0330; mem_busywait = 1'b1;
    #1;
    checks++;
    if (busywait !== 1'b1) begin
      errors++; $display("FAIL mid_busywait: got %b want 1", busywait);
    end
    step();
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 28'h000_0033) begin
      errors++; $display("FAIL mid_refill: got rd=%b addr=%h want 1 0000033", mem_read, mem_address);
    end
    reset = 1'b1; read = 1'b0;
    step();
    reset = 1'b0;
    #1;
    model_clear();
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || busywait !== 1'b0 || mem_address !== 28'd0) begin
      errors++;
      $display("FAIL reset_abort: got rd=%b wr=%b bw=%b addr=%h want 0 0 0 0",
               mem_read, mem_write, busywait, mem_address);
    end
    access(1'b1, 1'b0, 32'h0000_0330, 32'h0, 1, 1'b0);
  endtask

  task automatic test_drop_and_wrap();
    access(1'b1, 1'b0, 32'h0000_0444, 32'h0, 2, 1'b1);
    access(1'b1, 1'b0, 32'h0000_0444, 32'h0, 0, 1'b0);
    access(1'b0, 1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 1, 1'b0);
    access(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0070, 32'h0, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          op;
    for (int n = 0; n < 120; n++) begin
      a  = {25'(($urandom_range(0, 3)) * 25'h0_1F3D), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = int'($urandom_range(0, 2));
      access(op != 1, op != 0, a, $urandom, int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_read_write_both();
    test_reset_mid_refill();
    test_drop_and_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
